// File: rtl/sparc_control_unit.sv
// Hardwired Moore FSM control unit for the SPARC V8 subset datapath (format 3 ALU, load, store).
// Optional MFC watchdog enabled by defining MFC_TIMEOUT_EN (adds mem_timeout port).
module sparc_control_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [31:0] IR_Out,
  input  logic        MFC,
  output logic        NPC_enable,
  output logic        PC_enable,
  output logic        MDR_Enable,
  output logic        MAR_Enable,
  output logic        register_file_enable,
  output logic        RAM_enable,
  output logic        PSR_Enable,
  output logic [2:0]  extender_select,
  output logic [1:0]  PC_In_Mux_select,
  output logic [1:0]  ALUA_Mux_select,
  output logic [2:0]  ALUB_Mux_select,
  output logic        MDR_Mux_select,
  output logic [4:0]  in_PA,
  output logic [4:0]  in_PB,
  output logic [4:0]  in_PC,
  output logic [5:0]  ALU_op,
`ifdef MFC_TIMEOUT_EN
  output logic        mem_timeout,
`endif
  output logic [5:0]  RAM_OpCode
);

  typedef enum logic [3:0] {
    S_IDLE, S_ALU_EXEC, S_LD_MAR, S_LD_MEM, S_LD_WB,
    S_ST_MAR, S_ST_MDR, S_ST_MEM, S_FINISH
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_ir;
  logic        w_dispatch;
  logic        w_to_hit;
  logic        w_unused;

  wire [1:0] w_op  = r_ir[31:30];
  wire [4:0] w_rd  = r_ir[29:25];
  wire [5:0] w_op3 = r_ir[24:19];
  wire [4:0] w_rs1 = r_ir[18:14];
  wire       w_i   = r_ir[13];
  wire [4:0] w_rs2 = r_ir[4:0];

  wire [1:0] w_new_op  = IR_Out[31:30];
  wire [5:0] w_new_op3 = IR_Out[24:19];

  assign w_dispatch = (IR_Out != r_ir);
  assign w_unused   = ^{w_op, r_ir[12:5]};

`ifdef MFC_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_to_cnt;
  logic          r_mem_timeout;
  wire           w_mem_wait = (r_state == S_LD_MEM) || (r_state == S_ST_MEM);

  assign w_to_hit    = w_mem_wait && !MFC && (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_timeout = r_mem_timeout;

  always_ff @(posedge Clk) begin
    if (!RESET) begin
      r_to_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_mem_timeout <= w_to_hit;
      if (w_mem_wait && !MFC && !w_to_hit) r_to_cnt <= r_to_cnt + CW'(1);
      else                                 r_to_cnt <= '0;
    end
  end
`else
  logic w_unused_param;
  assign w_to_hit       = 1'b0;
  assign w_unused_param = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clk) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_dispatch) r_ir <= IR_Out;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dispatch) begin
          w_next = S_FINISH;
          if (w_new_op == 2'b10) w_next = S_ALU_EXEC;
          else if (w_new_op == 2'b11) begin
            case (w_new_op3)
              6'b000000, 6'b000001, 6'b000010: w_next = S_LD_MAR;
              6'b000100, 6'b000101, 6'b000110: w_next = S_ST_MAR;
              default:                         w_next = S_FINISH;
            endcase
          end
        end
      end
      S_ALU_EXEC: w_next = S_FINISH;
      S_LD_MAR:   w_next = S_LD_MEM;
      S_LD_MEM:   if (MFC) w_next = S_LD_WB; else if (w_to_hit) w_next = S_FINISH;
      S_LD_WB:    w_next = S_FINISH;
      S_ST_MAR:   w_next = S_ST_MDR;
      S_ST_MDR:   w_next = S_ST_MEM;
      S_ST_MEM:   if (MFC || w_to_hit) w_next = S_FINISH;
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    NPC_enable           = 1'b0;
    PC_enable            = 1'b0;
    MDR_Enable           = 1'b0;
    MAR_Enable           = 1'b0;
    register_file_enable = 1'b0;
    RAM_enable           = 1'b0;
    PSR_Enable           = 1'b0;
    extender_select      = '0;
    PC_In_Mux_select     = '0;
    ALUA_Mux_select      = '0;
    ALUB_Mux_select      = '0;
    MDR_Mux_select       = 1'b0;
    in_PA                = '0;
    in_PB                = '0;
    in_PC                = '0;
    ALU_op               = '0;
    RAM_OpCode           = '0;
    // Address and ALU stages share operand B selection: immediate or rs2.
    if (r_state == S_ALU_EXEC || r_state == S_LD_MAR || r_state == S_ST_MAR) begin
      in_PA = w_rs1;
      if (w_i) ALUB_Mux_select = 3'd1;
      else     in_PB = w_rs2;
    end
    case (r_state)
      S_ALU_EXEC: begin
        ALU_op               = w_op3;
        in_PC                = w_rd;
        register_file_enable = 1'b1;
        PSR_Enable           = w_op3[4];
      end
      S_LD_MAR, S_ST_MAR: MAR_Enable = 1'b1;
      S_ST_MDR: begin
        in_PB          = w_rd;
        MDR_Mux_select = 1'b1;
        MDR_Enable     = 1'b1;
      end
      S_ST_MEM: begin
        RAM_enable = 1'b1;
        RAM_OpCode = w_op3;
      end
      S_LD_MEM: begin
        RAM_enable = 1'b1;
        RAM_OpCode = w_op3;
        MDR_Enable = 1'b1;
      end
      S_LD_WB: begin
        ALU_op               = 6'b000010;
        ALUA_Mux_select      = 2'd3;
        ALUB_Mux_select      = 3'd3;
        in_PC                = w_rd;
        register_file_enable = 1'b1;
      end
      S_FINISH: begin
        PC_enable  = 1'b1;
        NPC_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparc_control_unit.sv
// Self-checking bench for sparc_control_unit: queue-of-steps reference model plus directed literal checks.
module tb_sparc_control_unit;

  localparam int TO = 16;

  logic        Clk = 1'b0;
  logic        RESET;
  logic [31:0] IR_Out;
  logic        MFC;
  logic        NPC_enable, PC_enable, MDR_Enable, MAR_Enable;
  logic        register_file_enable, RAM_enable, PSR_Enable;
  logic [2:0]  extender_select;
  logic [1:0]  PC_In_Mux_select, ALUA_Mux_select;
  logic [2:0]  ALUB_Mux_select;
  logic        MDR_Mux_select;
  logic [4:0]  in_PA, in_PB, in_PC;
  logic [5:0]  ALU_op, RAM_OpCode;
  logic        mem_timeout_w;

  sparc_control_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .RESET(RESET), .IR_Out(IR_Out), .MFC(MFC),
    .NPC_enable(NPC_enable), .PC_enable(PC_enable), .MDR_Enable(MDR_Enable),
    .MAR_Enable(MAR_Enable), .register_file_enable(register_file_enable),
    .RAM_enable(RAM_enable), .PSR_Enable(PSR_Enable),
    .extender_select(extender_select), .PC_In_Mux_select(PC_In_Mux_select),
    .ALUA_Mux_select(ALUA_Mux_select), .ALUB_Mux_select(ALUB_Mux_select),
    .MDR_Mux_select(MDR_Mux_select), .in_PA(in_PA), .in_PB(in_PB), .in_PC(in_PC),
    .ALU_op(ALU_op),
`ifdef MFC_TIMEOUT_EN
    .mem_timeout(mem_timeout_w),
`endif
    .RAM_OpCode(RAM_OpCode)
  );

`ifndef MFC_TIMEOUT_EN
  assign mem_timeout_w = 1'b0;
`endif

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       npc_en, pc_en, mdr_en, mar_en, rf_en, ram_en, psr_en;
    logic [2:0] ext;
    logic [1:0] pcmux, alua;
    logic [2:0] alub;
    logic       mdrmux;
    logic [4:0] pa, pb, pc;
    logic [5:0] aluop, ramop;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    wait_mfc;
    bit    to;
  } step_t;

  outs_t act;
  always_comb begin
    act        = '0;
    act.npc_en = NPC_enable;  act.pc_en  = PC_enable;   act.mdr_en = MDR_Enable;
    act.mar_en = MAR_Enable;  act.rf_en  = register_file_enable;
    act.ram_en = RAM_enable;  act.psr_en = PSR_Enable;  act.ext    = extender_select;
    act.pcmux  = PC_In_Mux_select; act.alua = ALUA_Mux_select; act.alub = ALUB_Mux_select;
    act.mdrmux = MDR_Mux_select; act.pa = in_PA; act.pb = in_PB; act.pc = in_PC;
    act.aluop  = ALU_op;      act.ramop = RAM_OpCode;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: each dispatched instruction becomes a list of expected output steps.
  step_t       q[$];
  logic [31:0] m_ir = '0;
  int          m_tcnt = 0;

  function automatic step_t finish_step(bit to);
    step_t s;
    s.o = '0; s.o.pc_en = 1'b1; s.o.npc_en = 1'b1; s.wait_mfc = 0; s.to = to;
    return s;
  endfunction

  task automatic build_steps(input logic [31:0] ir);
    logic [1:0] op;  logic [5:0] op3;  logic [4:0] rd, rs1, rs2;  bit imm;
    step_t s, b;
    op = ir[31:30]; rd = ir[29:25]; op3 = ir[24:19]; rs1 = ir[18:14];
    imm = ir[13]; rs2 = ir[4:0];
    b.o = '0; b.wait_mfc = 0; b.to = 0;
    b.o.pa = rs1;
    if (imm) b.o.alub = 3'd1; else b.o.pb = rs2;
    if (op == 2'b10) begin
      s = b; s.o.aluop = op3; s.o.pc = rd; s.o.rf_en = 1'b1; s.o.psr_en = op3[4];
      q.push_back(s);
    end else if (op == 2'b11 && (op3 == 6'd0 || op3 == 6'd1 || op3 == 6'd2)) begin
      s = b; s.o.mar_en = 1'b1; q.push_back(s);
      s.o = '0; s.o.ram_en = 1'b1; s.o.ramop = op3; s.o.mdr_en = 1'b1; s.wait_mfc = 1;
      q.push_back(s);
      s.o = '0; s.wait_mfc = 0; s.o.aluop = 6'b000010; s.o.alua = 2'd3; s.o.alub = 3'd3;
      s.o.pc = rd; s.o.rf_en = 1'b1; q.push_back(s);
    end else if (op == 2'b11 && (op3 == 6'd4 || op3 == 6'd5 || op3 == 6'd6)) begin
      s = b; s.o.mar_en = 1'b1; q.push_back(s);
      s.o = '0; s.o.pb = rd; s.o.mdrmux = 1'b1; s.o.mdr_en = 1'b1; q.push_back(s);
      s.o = '0; s.o.ram_en = 1'b1; s.o.ramop = op3; s.wait_mfc = 1; q.push_back(s);
    end
    q.push_back(finish_step(0));
  endtask

  always @(posedge Clk) begin
    if (!RESET) begin
      q.delete(); m_ir = '0; m_tcnt = 0;
    end else if (q.size() == 0) begin
      if (IR_Out != m_ir) begin
        m_ir = IR_Out;
        build_steps(IR_Out);
      end
    end else if (q[0].wait_mfc && !MFC) begin
`ifdef MFC_TIMEOUT_EN
      m_tcnt++;
      if (m_tcnt == TO) begin
        q.delete(); q.push_back(finish_step(1)); m_tcnt = 0;
      end
`endif
    end else begin
      void'(q.pop_front());
      m_tcnt = 0;
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    outs_t exp; bit exp_to;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      exp    = (q.size() != 0) ? q[0].o : '0;
      exp_to = (q.size() != 0) ? q[0].to : 1'b0;
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
      end
`ifdef MFC_TIMEOUT_EN
      total++;
      if (mem_timeout_w !== exp_to) begin
        bad++;
        $display("FAIL model_timeout t=%0t actual=%b required=%b", $time, mem_timeout_w, exp_to);
      end
`endif
    end
  end

  task automatic chk_lit(input string name, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int unsigned k;
    r = $urandom();
    k = $urandom_range(0, 9);
    if (k < 3) r[31:30] = 2'b10;
    else if (k < 8) begin
      r[31:30] = 2'b11;
      case ($urandom_range(0, 6))
        0: r[24:19] = 6'd0;  1: r[24:19] = 6'd1;  2: r[24:19] = 6'd2;
        3: r[24:19] = 6'd4;  4: r[24:19] = 6'd5;  5: r[24:19] = 6'd6;
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    outs_t e;
    RESET = 1'b0; IR_Out = 32'h82002003; MFC = 1'b0;
    step(); step();
    chk_lit("reset_zero", '0);
    RESET = 1'b1;
    step();
    e = '0; e.pa = 5'd0; e.alub = 3'd1; e.pc = 5'd1; e.rf_en = 1'b1; e.aluop = 6'd0;
    chk_lit("mov_exec", e);
    step();
    e = '0; e.pc_en = 1'b1; e.npc_en = 1'b1;
    chk_lit("mov_finish", e);
    step(); chk_lit("mov_idle", '0);
    step(); chk_lit("no_reexec", '0);

    IR_Out = 32'h84004002;
    step();
    e = '0; e.pa = 5'd1; e.pb = 5'd2; e.alub = 3'd0; e.pc = 5'd2; e.rf_en = 1'b1;
    chk_lit("add_exec", e);
    step();
    e = '0; e.pc_en = 1'b1; e.npc_en = 1'b1;
    chk_lit("add_finish_once", e);
    step();

    IR_Out = 32'hC420201E;
    step();
    e = '0; e.mar_en = 1'b1; e.alub = 3'd1;
    chk_lit("st_mar", e);
    step();
    e = '0; e.pb = 5'd2; e.mdrmux = 1'b1; e.mdr_en = 1'b1;
    chk_lit("st_mdr", e);
    step();
    e = '0; e.ram_en = 1'b1; e.ramop = 6'b000100;
    chk_lit("st_mem1", e);
    step(); step();
    chk_lit("st_mem3", e);
    MFC = 1'b1;
    step();
    MFC = 1'b0;
    e = '0; e.pc_en = 1'b1; e.npc_en = 1'b1;
    chk_lit("st_finish", e);
    step();

    IR_Out = 32'hC600201E;
    step(); step();
    e = '0; e.ram_en = 1'b1; e.ramop = 6'd0; e.mdr_en = 1'b1;
    chk_lit("ld_mem", e);
    step();
    MFC = 1'b1;
    step();
    MFC = 1'b0;
    e = '0; e.alua = 2'd3; e.alub = 3'd3; e.aluop = 6'b000010; e.pc = 5'd3; e.rf_en = 1'b1;
    chk_lit("ld_wb", e);
    step(); step();

    // Reset in the middle of a stalled store.
    IR_Out = 32'hC420201E;
    repeat (7) step();
    RESET = 1'b0;
    step();
    chk_lit("reset_mid_mem", '0);
    RESET = 1'b1;
    step(); step();
`ifdef MFC_TIMEOUT_EN
    repeat (TO) step();
    e = '0; e.pc_en = 1'b1; e.npc_en = 1'b1;
    chk_lit("timeout_finish", e);
    total++;
    if (mem_timeout_w !== 1'b1) begin
      bad++;
      $display("FAIL timeout_pulse actual=%b required=1", mem_timeout_w);
    end
`else
    repeat (40) step();
    e = '0; e.ram_en = 1'b1; e.ramop = 6'b000100;
    chk_lit("st_stall_hold", e);
`endif
    RESET = 1'b0;
    step();
    RESET = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      RESET = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 15) IR_Out = rand_instr();
      MFC = ($urandom_range(0, 99) < 40);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sparc_control_unit.md
Name: sparc_control_unit

Overview:
- Hardwired FSM control unit for the SPARC V8 subset datapath.
- Decodes the 32-bit instruction held in the datapath IR (format 3 arithmetic and load/store).
- Drives every register enable, mux select, register-file port address, ALU opcode and RAM command.
- Sequences RAM accesses using the datapath's MFC (memory function complete) handshake.

Parameters:
TIMEOUT_CYCLES, 16, max cycles to wait for MFC (used only with MFC_TIMEOUT_EN)

Ports:
- Clk  in  1  system clock, rising edge
- RESET  in  1  synchronous active-low reset
- IR_Out  in  32  current instruction from datapath IR
- MFC  in  1  memory function complete from RAM
- NPC_enable, PC_enable, MDR_Enable, MAR_Enable, register_file_enable, RAM_enable, PSR_Enable  out  1 each  register/RAM enables
- extender_select  out  3  0=sign-extend simm13; others reserved, drive 0
- PC_In_Mux_select  out  2  0=NPC; others reserved
- ALUA_Mux_select  out  2  0=out_PA, 1=PC, 2=NPC, 3=zero
- ALUB_Mux_select  out  3  0=out_PB, 1=extender_out, 2=const 4, 3=MDR
- MDR_Mux_select  out  1  0=RAM data out, 1=out_PB
- in_PA, in_PB, in_PC  out  5 each  RF read A, read B, write addresses
- ALU_op  out  6  ALU operation (SPARC op3 encoding; 000010=OR)
- RAM_OpCode  out  6  RAM access type (load/store op3)

Behaviour:
- Fields of latched ir_q:
  - op=[31:30], rd=[29:25], op3=[24:19], rs1=[18:14]
  - i=[13]; simm13=[12:0]; rs2=[4:0]
- Operand B for address/ALU stages: ALUB=1 if i=1, else ALUB=0 with in_PB=rs2.
- Outputs are a Moore decode of state plus ir_q. Anything not listed for a state is 0.
- Reset (RESET=0 at a rising edge):
  - State goes to IDLE, ir_q=0, timeout counter=0.
  - Every output is 0 from that edge on.
  - Reset mid-operation aborts the instruction at once; no further enables.
- IDLE:
  - A new instruction is dispatched when IR_Out != ir_q.
  - On dispatch, ir_q<=IR_Out. Next state follows from op/op3:
    - op=10 → ALU_EXEC.
    - op=11 with op3 in {000000 ld, 000001 ldub, 000010 lduh} → LD_MAR.
    - op=11 with op3 in {000100 st, 000101 stb, 000110 sth} → ST_MAR.
    - Anything else (including op=00/01) → FINISH (treated as a NOP).
  - An identical consecutive instruction is not re-executed.
- ALU_EXEC (1 cycle):
  - ALU_op=op3, in_PA=rs1, ALUA=0, operand B as above.
  - in_PC=rd, register_file_enable=1.
  - PSR_Enable=op3[4].
  - → FINISH.
- LD_MAR / ST_MAR (1 cycle):
  - ALU_op=000000, in_PA=rs1, ALUA=0, operand B as above.
  - MAR_Enable=1.
  - → LD_MEM / ST_MDR.
- ST_MDR (1 cycle): in_PB=rd, MDR_Mux_select=1, MDR_Enable=1 → ST_MEM.
- ST_MEM:
  - RAM_enable=1, RAM_OpCode=op3.
  - Hold until MFC=1 is sampled → FINISH.
- LD_MEM:
  - RAM_enable=1, RAM_OpCode=op3, MDR_Mux_select=0, MDR_Enable=1.
  - Hold until MFC=1 is sampled → LD_WB.
- LD_WB (1 cycle):
  - ALU_op=000010, ALUA=3, ALUB=3.
  - in_PC=rd, register_file_enable=1.
  - → FINISH.
- FINISH (1 cycle): PC_enable=1, PC_In_Mux_select=0, NPC_enable=1 (NPC increments by 4 in datapath) → IDLE.
- Latency from dispatch edge:
  - ALU instruction: 2 cycles.
  - Store: 4 + MFC wait cycles.
  - Load: 4 + MFC wait cycles.
- MFC already high on the first RAM cycle completes that cycle (1-cycle access).
- IR_Out changes during an operation are ignored until IDLE.

Optional Feature:
- Macro: MFC_TIMEOUT_EN.
- Defined:
  - Adds output port mem_timeout (1 bit).
  - In ST_MEM/LD_MEM, counts cycles without MFC.
  - After TIMEOUT_CYCLES cycles, goes to FINISH (skipping LD_WB, no RF write).
  - mem_timeout pulses 1 for one cycle on that transition; reset clears it.
- Undefined:
  - No port and no counter.
  - The FSM waits for MFC indefinitely.

Test Plan:
- RESET=0 for 2 cycles with IR_Out=0x82002003 → all outputs 0 and no dispatch. After RESET=1, dispatch next edge.
- IR_Out=0x82002003 (mov r1,#3) → ALU_EXEC shows:
  - ALU_op=0, in_PA=0, ALUA=0, ALUB=1, extender_select=0.
  - in_PC=1, register_file_enable=1, PSR_Enable=0.
  - Then FINISH with PC_enable=NPC_enable=1, then IDLE; IR held → no re-execution.
- IR_Out=0x84004002 (add r2,r1,r2) → ALU_EXEC with in_PA=1, in_PB=2, ALUB=0, in_PC=2, register_file_enable=1 for exactly one cycle.
- IR_Out=0xC420201E (st r2,[30]), MFC high 3 cycles after ST_MEM entry:
  - MAR_Enable one cycle, then MDR_Enable with in_PB=2, MDR_Mux_select=1.
  - RAM_enable=1 with RAM_OpCode=000100 held until MFC, then FINISH.
- IR_Out=0xC600201E (ld r3,[30]):
  - LD_MEM with RAM_OpCode=0, MDR_Enable=1, MDR_Mux_select=0 until MFC.
  - Then LD_WB with ALUA=3, ALUB=3, ALU_op=000010, in_PC=3, register_file_enable=1.
- Store with MFC never asserted:
  - Without macro, stays in ST_MEM.
  - With MFC_TIMEOUT_EN, TIMEOUT_CYCLES=16: mem_timeout pulses after 16 cycles, then FINISH, IDLE.
  - RESET=0 asserted mid-ST_MEM → all outputs 0 after that edge.
